// File: rtl/ariane_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : ariane_pkg                                              |
// | Description : Shared frontend types: BTB update record and the depth  |
// |               used when instantiating the BTB update queue.           |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package ariane_pkg;

  localparam int unsigned VLEN = 64;

  // One write request toward the BTB: PC of the indirect jump and its target.
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_update_t;

  localparam int unsigned BTB_UPDATE_QUEUE_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/btb_update_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : btb_update_queue                                        |
// | Description : Buffers resolved JALR mispredicts for the BTB write     |
// |               port. Filters ineligible resolutions, merges repeated   |
// |               PCs into queued entries and drops when full.            |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module btb_update_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH    = BTB_UPDATE_QUEUE_DEPTH,
  parameter bit          COALESCE = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       resolve_valid_i,
  input  logic [63:0]                resolve_pc_i,
  input  logic [63:0]                resolve_target_i,
  input  logic                       resolve_mispredict_i,
  input  logic                       resolve_is_jalr_i,
  input  logic                       update_ready_i,
  output btb_update_t                btb_update_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned        c_PTR_W = $clog2(DEPTH);
  localparam int unsigned        c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  // Entry storage kept flat so every entry can be compared in parallel.
  logic [63:0]        r_pc  [DEPTH];
  logic [63:0]        r_tgt [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic               w_eligible;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_full;
  logic               w_hit;
  logic               w_enq;
  logic               w_drop;
  logic [DEPTH-1:0]   w_hit_vec;
  logic [c_PTR_W-1:0] w_hit_idx;

  // Only indirect mispredicts outside debug and flush reach the queue.
  assign w_eligible  = resolve_valid_i & resolve_mispredict_i & resolve_is_jalr_i
                     & ~debug_mode_i & ~flush_i;
  assign w_out_valid = (r_count != '0) & ~debug_mode_i & ~flush_i;
  assign w_pop       = w_out_valid & update_ready_i;
  assign w_full      = (r_count == c_FULL);

  // The head is never a merge target so the data on the output stays stable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_hit_vec[gi] = COALESCE && r_valid[gi] && (c_PTR_W'(gi) != r_head)
                           && (r_pc[gi] == resolve_pc_i);
  end

  // Pick the lowest matching index; at most one non-head entry holds a PC.
  always_comb begin
    w_hit_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit_idx = c_PTR_W'(i);
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_hit  = w_eligible & (|w_hit_vec);
  assign w_enq  = w_eligible & ~w_hit & (~w_full | w_pop);
  assign w_drop = w_eligible & ~w_hit & w_full & ~w_pop;

  // Pointer, count and valid bookkeeping; reset and flush empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pop clears before enqueue sets, so a full-queue pop+push keeps the slot valid.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_PTR_W'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_PTR_W'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload writes: new entry at the tail or a target refresh on merge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_enq) begin
        r_pc[r_tail]  <= resolve_pc_i;
        r_tgt[r_tail] <= resolve_target_i;
      end
      if (w_hit) begin
        r_tgt[w_hit_idx] <= resolve_target_i;
      end
    end
  end

  // Present the head entry; no bypass from the input side.
  always_comb begin
    btb_update_o                = '0;
    btb_update_o.valid          = w_out_valid;
    btb_update_o.pc             = r_pc[r_head];
    btb_update_o.target_address = r_tgt[r_head];
  end

  assign drop_o      = w_drop;
  assign occupancy_o = r_count;

endmodule
`default_nettype wire
